// File: rtl/vectored_interrupt_controller_pkg.sv
// Shared definitions for the vectored interrupt controller.
//  - AMBER_VIC_* : register byte offsets decoded from wishbone address bits [7:0]
//  - VIC_UNMAPPED_READ : value returned for reads of unmapped/write-only offsets
//  - vic_vector() : packs {valid, 26'd0, idx} into a vector register word
package vectored_interrupt_controller_pkg;

  localparam logic [7:0] AMBER_VIC_IRQ_STATUS  = 8'h00;
  localparam logic [7:0] AMBER_VIC_RAWSTAT     = 8'h04;
  localparam logic [7:0] AMBER_VIC_IRQ_ENSET   = 8'h08;
  localparam logic [7:0] AMBER_VIC_IRQ_ENCLR   = 8'h0C;
  localparam logic [7:0] AMBER_VIC_FIRQ_STATUS = 8'h10;
  localparam logic [7:0] AMBER_VIC_FIRQ_ENSET  = 8'h14;
  localparam logic [7:0] AMBER_VIC_FIRQ_ENCLR  = 8'h18;
  localparam logic [7:0] AMBER_VIC_MODE        = 8'h1C;
  localparam logic [7:0] AMBER_VIC_PENDING     = 8'h20;
  localparam logic [7:0] AMBER_VIC_SOFTSET     = 8'h24;
  localparam logic [7:0] AMBER_VIC_SOFTCLR     = 8'h28;
  localparam logic [7:0] AMBER_VIC_IRQ_VECTOR  = 8'h2C;
  localparam logic [7:0] AMBER_VIC_FIRQ_VECTOR = 8'h30;

  localparam logic [31:0] VIC_UNMAPPED_READ = 32'h2233_4455;

  // A vector word with no active source reads as all zeros.
  function automatic logic [31:0] vic_vector(input logic valid, input logic [4:0] idx);
    return valid ? {1'b1, 26'd0, idx} : 32'd0;
  endfunction

endpackage

// File: rtl/vectored_interrupt_controller_if.sv
// Wishbone slave bus bundle for the interrupt controller.
//  i_wb_adr/sel/we/dat/cyc/stb : master -> slave request
//  o_wb_dat/ack/err            : slave -> master response
// Signal names keep the slave-side i_/o_ prefixes of the Amber bus.
interface vectored_interrupt_controller_if #(
  parameter int WB_DWIDTH = 32,
  parameter int WB_SWIDTH = 4
);
  logic [31:0]          i_wb_adr;
  logic [WB_SWIDTH-1:0] i_wb_sel;
  logic                 i_wb_we;
  logic [WB_DWIDTH-1:0] o_wb_dat;
  logic [WB_DWIDTH-1:0] i_wb_dat;
  logic                 i_wb_cyc;
  logic                 i_wb_stb;
  logic                 o_wb_ack;
  logic                 o_wb_err;

  modport master (
    output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    input  o_wb_dat, o_wb_ack, o_wb_err
  );

  modport slave (
    input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    output o_wb_dat, o_wb_ack, o_wb_err
  );
endinterface

// File: rtl/vic_prio_enc.sv
// Lowest-index-first priority encoder.
//  req   : N request bits (N <= 32)
//  valid : any request set
//  idx   : index of the lowest set request bit, 0 when none
module vic_prio_enc #(
  parameter int N = 32
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [4:0]   idx
);
  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    idx = 5'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 5'(i);
    end
  end

  assign valid = |req;
endmodule

// File: rtl/vectored_interrupt_controller.sv
// Vectored interrupt controller, wishbone slave.
//  i_clk, i_rst : clock and synchronous active-high reset
//  wb           : wishbone slave port (32- or 128-bit data)
//  i_int        : interrupt sources, synchronous to i_clk; bit 0 is the soft-interrupt slot
//  o_irq/o_firq : registered interrupt requests
// Each source is level or rising-edge (sticky pending) per MODE; IRQ and FIRQ have
// independent enable masks and lowest-index vector registers.
module vectored_interrupt_controller
  import vectored_interrupt_controller_pkg::*;
#(
  parameter int WB_DWIDTH = 32,
  parameter int WB_SWIDTH = 4,
  parameter int NUM_SRC   = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  vectored_interrupt_controller_if.slave wb,
  input  logic [NUM_SRC-1:0]             i_int,
  output logic                           o_irq,
  output logic                           o_firq
);
  // Hardware sources start at bit 1; bit 0 belongs to the soft interrupt.
  localparam logic [NUM_SRC-1:0] EXT_MASK = ~NUM_SRC'(1);

  logic [7:0]         adr;
  logic [31:0]        wdata, rdata_reg, rdata_next;
  logic               start_write, start_read, start_read_d1_reg, ack;
  logic [NUM_SRC-1:0] irq_en_reg, firq_en_reg, mode_reg, pending_reg, prev_reg;
  logic [NUM_SRC-1:0] pending_next, pend_set, wsrc, rise, eff, irq_status, firq_status;
  logic               soft_reg, irq_reg, firq_reg;
  logic               wr_mode, wr_pend_clr;
  logic               irq_valid, firq_valid;
  logic [4:0]         irq_idx, firq_idx;
  logic [WB_SWIDTH-1:0] unused_sel;
  logic               unused_misc;

  assign unused_sel  = wb.i_wb_sel;
  assign unused_misc = ^{wb.i_wb_cyc, wb.i_wb_adr[31:8]};

  assign adr = wb.i_wb_adr[7:0];

  // Wide bus: write lane chosen by adr[3:2]; read word replicated on every lane.
  generate
    if (WB_DWIDTH == 128) begin : g_w128
      assign wdata = wb.i_wb_dat[{wb.i_wb_adr[3:2], 5'd0} +: 32];
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wb.o_wb_dat[gi*32 +: 32] = rdata_reg;
      end
    end else begin : g_w32
      assign wdata     = wb.i_wb_dat[31:0];
      assign wb.o_wb_dat = rdata_reg;
    end
  endgenerate

  // Writes ack in the request cycle; reads ack one cycle later, after the
  // read data register has captured the addressed value.
  assign start_write = wb.i_wb_stb & wb.i_wb_we & ~start_read_d1_reg;
  assign start_read  = wb.i_wb_stb & ~wb.i_wb_we & ~ack;
  assign ack         = wb.i_wb_stb & (start_write | start_read_d1_reg);
  assign wb.o_wb_ack = ack;
  assign wb.o_wb_err = 1'b0;

  assign wsrc        = wdata[NUM_SRC-1:0];
  assign wr_mode     = start_write && (adr == AMBER_VIC_MODE);
  assign wr_pend_clr = start_write && (adr == AMBER_VIC_PENDING);

  assign rise = i_int & ~prev_reg & EXT_MASK;
  assign eff  = (((mode_reg & pending_reg) | (~mode_reg & i_int)) & EXT_MASK)
              | NUM_SRC'(soft_reg);
  assign irq_status  = eff & irq_en_reg;
  assign firq_status = eff & firq_en_reg;

  // A new edge beats a same-cycle software clear; switching a source to
  // level mode drops its pending bit, including an edge arriving that cycle.
  always_comb begin
    pend_set     = mode_reg & rise;
    pending_next = pending_reg;
    if (wr_pend_clr) pending_next = pending_next & ~wsrc;
    if (wr_mode) begin
      pending_next = pending_next & wsrc;
      pend_set     = pend_set & wsrc;
    end
    pending_next = (pending_next | pend_set) & EXT_MASK;
  end

  vic_prio_enc #(.N(NUM_SRC)) u_irq_enc  (.req(irq_status),  .valid(irq_valid),  .idx(irq_idx));
  vic_prio_enc #(.N(NUM_SRC)) u_firq_enc (.req(firq_status), .valid(firq_valid), .idx(firq_idx));

  always_comb begin
    rdata_next = VIC_UNMAPPED_READ;
    case (adr)
      AMBER_VIC_IRQ_STATUS:  rdata_next = 32'(irq_status);
      AMBER_VIC_RAWSTAT:     rdata_next = 32'(eff);
      AMBER_VIC_IRQ_ENSET:   rdata_next = 32'(irq_en_reg);
      AMBER_VIC_FIRQ_STATUS: rdata_next = 32'(firq_status);
      AMBER_VIC_FIRQ_ENSET:  rdata_next = 32'(firq_en_reg);
      AMBER_VIC_MODE:        rdata_next = 32'(mode_reg);
      AMBER_VIC_PENDING:     rdata_next = 32'(pending_reg);
      AMBER_VIC_SOFTSET,
      AMBER_VIC_SOFTCLR:     rdata_next = {31'd0, soft_reg};
      AMBER_VIC_IRQ_VECTOR:  rdata_next = vic_vector(irq_valid, irq_idx);
      AMBER_VIC_FIRQ_VECTOR: rdata_next = vic_vector(firq_valid, firq_idx);
      default:               rdata_next = VIC_UNMAPPED_READ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      irq_en_reg        <= '0;
      firq_en_reg       <= '0;
      mode_reg          <= '0;
      pending_reg       <= '0;
      prev_reg          <= '0;
      soft_reg          <= 1'b0;
      rdata_reg         <= '0;
      start_read_d1_reg <= 1'b0;
      irq_reg           <= 1'b0;
      firq_reg          <= 1'b0;
    end else begin
      prev_reg          <= i_int;
      pending_reg       <= pending_next;
      start_read_d1_reg <= start_read;
      irq_reg           <= |irq_status;
      firq_reg          <= |firq_status;
      if (start_read) rdata_reg <= rdata_next;
      if (start_write) begin
        case (adr)
          AMBER_VIC_IRQ_ENSET:  irq_en_reg  <= irq_en_reg | wsrc;
          AMBER_VIC_IRQ_ENCLR:  irq_en_reg  <= irq_en_reg & ~wsrc;
          AMBER_VIC_FIRQ_ENSET: firq_en_reg <= firq_en_reg | wsrc;
          AMBER_VIC_FIRQ_ENCLR: firq_en_reg <= firq_en_reg & ~wsrc;
          AMBER_VIC_MODE:       mode_reg    <= wsrc;
          AMBER_VIC_SOFTSET:    if (wdata[0]) soft_reg <= 1'b1;
          AMBER_VIC_SOFTCLR:    if (wdata[0]) soft_reg <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign o_irq  = irq_reg;
  assign o_firq = firq_reg;
endmodule
